// File: rtl/serial_pkg.sv
// Constants and state type shared by both ends of the serial link.
// The receiver takes its idle character from this package too.
package serial_pkg;

    localparam logic [7:0]  IDLE_CHAR      = 8'hBC;
    localparam int unsigned MIN_SYNC_BYTES = 6;

    typedef enum logic {
        SYNC,
        RUN
    } tx_state_e;

endpackage

// File: rtl/partoserial0_shift_out8.sv
// 8-bit load/shift register feeding the serial line, MSB first.
// Zeros shift in from the bottom between loads.
module shift_out8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] din,
    output logic       msb
);

    logic [7:0] shreg_q;
    logic [7:0] shreg_d;

    always_comb begin
        shreg_d = {shreg_q[6:0], 1'b0};
        if (load) begin
            shreg_d = din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb = shreg_q[7];

endmodule

// File: rtl/partoserial0.sv
// Byte-to-serial transmitter: sync burst of idle characters after reset,
// then payload bytes via valid/ready, idle characters in every empty slot.
module partoserial0 #(
    parameter int unsigned SYNC_BYTES = 6,
    parameter logic [7:0]  IDLE_CHAR  = 8'hBC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_outser,
    output logic       sync_done,
    output logic       bc_collision
);

    import serial_pkg::*;

    localparam int unsigned SYNC_W = $clog2(SYNC_BYTES + 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_BYTES - 1);

    tx_state_e         state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
    logic              sync_done_q, sync_done_d;
    logic              bc_collision_q, bc_collision_d;

    logic              boundary;
    logic              ready;
    logic              transfer;
    logic [7:0]        load_byte;

    always_comb begin
        boundary       = (bit_cnt_q == 3'd7);
        ready          = (state_q == RUN) && boundary;
        transfer       = ready && valid_in;
        load_byte      = transfer ? data_in : IDLE_CHAR;
        bit_cnt_d      = bit_cnt_q + 3'd1;
        state_d        = state_q;
        sync_cnt_d     = sync_cnt_q;
        bc_collision_d = transfer && (data_in == IDLE_CHAR);

        // Switching to RUN as the last sync character is loaded lets ready
        // rise on that character's final bit, so payload follows it directly.
        if ((state_q == SYNC) && boundary) begin
            if (sync_cnt_q == SYNC_LAST) begin
                state_d = RUN;
            end else begin
                sync_cnt_d = sync_cnt_q + 1'b1;
            end
        end

        sync_done_d = sync_done_q || ((state_d == RUN) && (bit_cnt_d == 3'd7));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= SYNC;
            bit_cnt_q      <= 3'd7;
            sync_cnt_q     <= '0;
            sync_done_q    <= 1'b0;
            bc_collision_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            sync_cnt_q     <= sync_cnt_d;
            sync_done_q    <= sync_done_d;
            bc_collision_q <= bc_collision_d;
        end
    end

    shift_out8 u_shift (
        .clk   (clk),
        .reset (reset),
        .load  (boundary),
        .din   (load_byte),
        .msb   (data_outser)
    );

    assign ready_out    = ready;
    assign sync_done    = sync_done_q;
    assign bc_collision = bc_collision_q;

    // Payload is only accepted after the burst has completed.
    a_ready_after_sync : assert property (@(posedge clk) disable iff (reset)
        ready_out |-> sync_done);

    a_sync_sticky : assert property (@(posedge clk) disable iff (reset)
        sync_done |=> sync_done);

endmodule

// File: tb/tb_partoserial0.sv
// Randomized bench for partoserial0 against a slot-level line model.
module tb_partoserial0;

    localparam int unsigned SYNC_BYTES = 6;
    localparam logic [7:0]  IDLE       = 8'hBC;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_outser;
    logic       sync_done;
    logic       bc_collision;

    always #5 clk = ~clk;

    partoserial0 #(
        .SYNC_BYTES (SYNC_BYTES),
        .IDLE_CHAR  (IDLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .data_outser  (data_outser),
        .sync_done    (sync_done),
        .bc_collision (bc_collision)
    );

    int checks = 0;
    int errors = 0;

    // Model state: cyc counts cycles since the first edge with reset low.
    int         cyc;
    logic [7:0] slots[$];
    logic [7:0] src_q[$];
    logic [7:0] rx_exp[$];
    int         xfer_cyc[$];
    int         coll_at;
    logic [7:0] rx_sh;
    bit         hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc = -1;
        slots.delete();
        for (int i = 0; i < int'(SYNC_BYTES); i++) slots.push_back(IDLE);
        rx_exp.delete();
        xfer_cyc.delete();
        coll_at = -10;
        rx_sh = '0;
    endtask

    task automatic step(input bit do_reset);
        bit         exp_ready;
        logic [7:0] slot_byte;
        reset = do_reset;
        @(posedge clk);
        #1;
        exp_ready = 1'b0;
        if (do_reset) begin
            model_reset();
            check("rst_line", data_outser, 1'b0);
            check("rst_ready", ready_out, 1'b0);
            check("rst_sync_done", sync_done, 1'b0);
            check("rst_coll", bc_collision, 1'b0);
        end else begin
            cyc++;
            while (slots.size() <= cyc / 8) slots.push_back(IDLE);
            slot_byte = slots[cyc / 8];
            exp_ready = (cyc >= 8 * int'(SYNC_BYTES) - 1) && (cyc % 8 == 7);
            check("line", data_outser, slot_byte[7 - cyc % 8]);
            check("ready", ready_out, exp_ready);
            check("sync_done", sync_done, cyc >= 8 * int'(SYNC_BYTES) - 1);
            check("bc_collision", bc_collision, cyc == coll_at);
            if (cyc >= 8 * int'(SYNC_BYTES)) begin
                rx_sh = {rx_sh[6:0], data_outser};
                if ((cyc % 8 == 7) && (rx_sh != IDLE)) begin
                    if (rx_exp.size() == 0) check("loopback_extra", rx_sh, IDLE);
                    else check("loopback", rx_sh, rx_exp.pop_front());
                end
            end
        end
        // Inputs for the edge closing this cycle.
        valid_in = (src_q.size() > 0) && (hold || ($urandom_range(0, 1) == 1));
        data_in  = valid_in ? src_q[0] : 8'($urandom);
        if (do_reset) begin
            valid_in = 1'b1;
        end else if (valid_in && exp_ready) begin
            slots.push_back(src_q[0]);
            if (src_q[0] == IDLE) coll_at = cyc + 1;
            else rx_exp.push_back(src_q[0]);
            xfer_cyc.push_back(cyc);
            void'(src_q.pop_front());
        end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((src_q.size() > 0) && (n < limit)) begin
            step(1'b0);
            n++;
        end
        if (src_q.size() > 0) check("drain_timeout", src_q.size(), 0);
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        hold     = 1'b0;
        model_reset();

        repeat (3) step(1'b1);
        repeat (40) step(1'b0);

        // Single byte held from R+40: accepted in the first ready cycle.
        hold = 1'b1;
        src_q.push_back(8'hA5);
        drain(100);
        check("first_accept_cycle", xfer_cyc.size() > 0 ? xfer_cyc[0] : -1, 8 * SYNC_BYTES - 1);
        repeat (20) step(1'b0);

        // Random payload with occasional idle-character collisions.
        hold = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) src_q.push_back(IDLE);
            else src_q.push_back(8'($urandom));
        end
        drain(3000);
        repeat (16) step(1'b0);

        // Back-to-back with valid held: one byte per 8 cycles.
        hold = 1'b1;
        xfer_cyc.delete();
        src_q.push_back(8'h01);
        src_q.push_back(8'h02);
        src_q.push_back(8'h03);
        drain(100);
        check("b2b_count", xfer_cyc.size(), 3);
        if (xfer_cyc.size() == 3) begin
            check("b2b_gap1", xfer_cyc[1] - xfer_cyc[0], 8);
            check("b2b_gap2", xfer_cyc[2] - xfer_cyc[1], 8);
        end
        repeat (30) step(1'b0);

        // Reset with 0xFF partly sent (bit_cnt = 3).
        src_q.push_back(8'hFF);
        drain(100);
        repeat (4) step(1'b0);
        step(1'b1);
        hold = 1'b0;
        repeat (60) step(1'b0);

        // Loopback payload after the restarted burst.
        hold = 1'b1;
        src_q.push_back(8'h11);
        src_q.push_back(8'h22);
        src_q.push_back(8'h33);
        drain(100);
        repeat (30) step(1'b0);
        check("loopback_drained", rx_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/partoserial0.md
# partoserial0

Byte-to-serial transmitter for the serial link; it is the sending end for the serial-to-parallel receiver. It takes 8-bit words through a valid/ready handshake and shifts them out MSB first on a single bit-rate clock. After reset it sends a burst of 0xBC sync characters, and it fills every idle byte slot with 0xBC, so the far-end receiver can lock and then tell payload from idle. It sits on the transmit side of the link, between the byte-level datapath and the serial line.

## Interface
- `SYNC_BYTES`, default 6: number of consecutive 0xBC characters sent after reset before payload is accepted. Must be at least 6, so the receiver sees more than 4 consecutive BC.
- `IDLE_CHAR`, default 8'hBC: idle/sync character.
- `clk`  in  1: bit-rate clock. The block has exactly one clock.
- `reset`  in  1: synchronous, active-high reset.
- `data_in`  in  8: parallel payload byte.
- `valid_in`  in  1: `data_in` is valid this cycle.
- `ready_out`  out  1: block accepts `data_in` this cycle if `valid_in` is high.
- `data_outser`  out  1: serial line, MSB first.
- `sync_done`  out  1: high once the sync burst is complete; stays high until reset.
- `bc_collision`  out  1: one-cycle pulse when an accepted payload byte equals `IDLE_CHAR`.

## Operation
- FSM states:
  - SYNC: send `IDLE_CHAR` repeatedly and never accept payload.
  - RUN: at each byte boundary, send the accepted payload byte, or `IDLE_CHAR` if none is offered.
- Transitions:
  - SYNC→RUN at the byte boundary that completes the `SYNC_BYTES`-th sync character.
  - RUN→SYNC only on `reset`.
- Byte boundary: `bit_cnt` == 7.
  - At each boundary the 8-bit shift register loads the next byte and `bit_cnt` wraps to 0.
  - On every other cycle the shift register shifts left by one and `bit_cnt` increments.
- `data_outser` is always `shreg[7]`, a registered output with no combinational path from any input.
- `ready_out` = (state == RUN) && (`bit_cnt` == 7). It depends only on registers.
- Handshake:
  - Transfer happens when `valid_in` && `ready_out`.
  - `valid_in` outside the ready cycle is ignored, with no buffering. The upstream block holds data until it sees ready.
- Byte loaded at a boundary:
  - transfer occurs: `data_in`.
  - otherwise: `IDLE_CHAR`.
- `bc_collision` pulses on the cycle after a transfer with `data_in` == `IDLE_CHAR`. The byte is still sent unmodified; the receiver will treat it as idle.
- `sync_cnt` counts loaded sync characters from 0 to `SYNC_BYTES`-1 and saturates. Its width is $clog2(`SYNC_BYTES`+1).
- Reset values:
  - `shreg` = 0, `data_outser` = 0, `bit_cnt` = 7, `sync_cnt` = 0, state = SYNC.
  - `ready_out` = 0, `sync_done` = 0, `bc_collision` = 0.
- Reset mid-byte: the partial byte is abandoned immediately. The line drops to 0 on the reset edge and the sync burst restarts.
- `reset` has priority over every other input.

## Timing
- Cycle R: first rising edge with `reset` low. `IDLE_CHAR` loads (`bit_cnt` 7 → 0).
  - `data_outser` = 1 from R, bit 7 of 0xBC.
- Each byte occupies exactly 8 cycles on `data_outser`.
- The line is continuously framed, with no gaps between bytes.
- `sync_done` and `ready_out` rise together, on the boundary cycle of the last sync byte:
  - `ready_out` first high at R + 8·`SYNC_BYTES` − 1.
  - The first payload MSB appears at R + 8·`SYNC_BYTES`.
- Transfer latency: a transfer at edge T puts `data_in[7]` on the line after T. `data_in[0]` is on the line at T+7.
- Sustained throughput: one byte per 8 cycles when `valid_in` is held high.

## Structure
- Shared package `serial_pkg`: `IDLE_CHAR` constant (8'hBC), `MIN_SYNC_BYTES` (6), and the state enum {SYNC, RUN}.
- The receiver also takes its `IDLE_CHAR` constant from this package.
- One sub-module: `shift_out8`, an 8-bit load/shift register with `load`, `din[7:0]` and `msb` out.
- The FSM, counters and handshake live in the top module.

## Test plan
- Reset then idle: assert reset for 3 cycles, release with `valid_in`=0.
  - Line carries 10111100 repeated.
  - `ready_out` first high at R+47.
  - `sync_done` rises at R+47.
- Single byte: offer 8'hA5 held from R+40.
  - Accepted at R+47.
  - Line from R+48 is 10100101, then 0xBC idle.
- Back-to-back: hold `valid_in` with 0x01, 0x02, 0x03, each advanced on transfer.
  - Three transfers exactly 8 cycles apart.
  - Bits 00000001 00000010 00000011 with no inserted idle.
- Collision: send 8'hBC as payload.
  - `bc_collision` pulses one cycle after the transfer.
  - Line shows 10111100.
- Reset mid-byte: assert reset at `bit_cnt`=3 of payload 0xFF.
  - `data_outser`=0 after the edge.
  - After release, the full 6-byte BC burst repeats and `sync_done`=0 until R+47.
- Loopback: feed `data_outser` to the receiver, clocked at 8f by `clk` with an 8-cycle-divided byte clock.
  - Payload 0x11, 0x22, 0x33 reappears in parallel with valid asserted.
